// File: rtl/pmodcolor_i2c_target_if.sv
// Pmod-side pin bundle of the PmodCOLOR I2C target: I2C pads, interrupt and sample port.
interface pmodcolor_i2c_target_if;
    localparam int unsigned SAMPLE_W = 16;

    logic                scl_i;
    logic                sda_i;
    logic                sda_o;
    logic                sda_t;
    logic                int_n;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_c;
    logic [SAMPLE_W-1:0] sample_r;
    logic [SAMPLE_W-1:0] sample_g;
    logic [SAMPLE_W-1:0] sample_b;

    modport master (
        output scl_i, sda_i, sample_valid, sample_c, sample_r, sample_g, sample_b,
        input  sda_o, sda_t, int_n
    );

    modport slave (
        input  scl_i, sda_i, sample_valid, sample_c, sample_r, sample_g, sample_b,
        output sda_o, sda_t, int_n
    );
endinterface

// File: rtl/pmodcolor_i2c_target.sv
// PmodCOLOR (TCS3472-style) I2C responder with register map, sample capture and interrupt.
// Optional input glitch filter: define PMODCOLOR_TARGET_GLITCH_FILTER_EN.
module pmodcolor_i2c_target #(
    parameter logic [6:0] I2C_ADDR  = 7'h29,
    parameter logic [7:0] DEVICE_ID = 8'h44
) (
    input  logic                  clk,
    input  logic                  rst,
    pmodcolor_i2c_target_if.slave bus
);
    localparam int unsigned PTR_W       = 5;
    localparam int unsigned CNT_W       = 4;
    localparam logic [7:0]  ENABLE_MASK = 8'h13;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    state_t state, state_next;

    logic [1:0]  scl_sync, sda_sync;
    logic        scl_lv, sda_lv;
    logic        scl_d, sda_d;
    logic        ev_rise, ev_fall, ev_start, ev_stop, bit_in;

    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       rx, tx;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             auto_inc, rd_mode, mack;
    logic             sda_t_q, sda_t_next, int_n_q;
    logic [7:0]       enable, atime;
    logic             aint, avalid;
    logic [3:0][15:0] live, snap;

    logic       cnt_clr, cnt_inc, rx_shift, mack_latch, addr_hit, cmd_hit, wr_en;
    logic       tx_load, tx_shift, ptr_inc, byte_full, cmd_ok, cmd_sf;
    logic [7:0] tx_val, rd_cur, rd_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
        end
    end

`ifdef PMODCOLOR_TARGET_GLITCH_FILTER_EN
    // A new level is taken once three consecutive samples agree; sync[0] is the newest.
    logic scl_f, sda_f, scl_pend, sda_pend, scl_acc, sda_acc;

    assign scl_acc = scl_pend && (scl_sync[1] != scl_f) && (scl_sync[0] == scl_sync[1]);
    assign sda_acc = sda_pend && (sda_sync[1] != sda_f) && (sda_sync[0] == sda_sync[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_pend <= 1'b0;
            sda_pend <= 1'b0;
        end else begin
            scl_pend <= (scl_sync[1] != scl_f) && !scl_acc;
            sda_pend <= (sda_sync[1] != sda_f) && !sda_acc;
            if (scl_acc) scl_f <= scl_sync[1];
            if (sda_acc) sda_f <= sda_sync[1];
        end
    end

    assign scl_lv = scl_f;
    assign sda_lv = sda_f;
`else
    assign scl_lv = scl_sync[1];
    assign sda_lv = sda_sync[1];
`endif

    // Registered bus events; bit_in stays aligned with ev_rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            ev_rise  <= 1'b0;
            ev_fall  <= 1'b0;
            ev_start <= 1'b0;
            ev_stop  <= 1'b0;
            bit_in   <= 1'b1;
        end else begin
            scl_d    <= scl_lv;
            sda_d    <= sda_lv;
            ev_rise  <= scl_lv & ~scl_d;
            ev_fall  <= ~scl_lv & scl_d;
            ev_start <= scl_lv & scl_d & sda_d & ~sda_lv;
            ev_stop  <= scl_lv & scl_d & ~sda_d & sda_lv;
            bit_in   <= sda_lv;
        end
    end

    function automatic logic [7:0] rd_mux(input logic [PTR_W-1:0] a, input logic [7:0] en,
                                          input logic [7:0] at, input logic ai, input logic av,
                                          input logic [3:0][15:0] sn);
        logic [2:0] idx;
        idx = 3'(a - 5'h14);
        case (a)
            5'h00:   rd_mux = en;
            5'h01:   rd_mux = at;
            5'h12:   rd_mux = DEVICE_ID;
            5'h13:   rd_mux = {3'b000, ai, 3'b000, av};
            5'h14, 5'h15, 5'h16, 5'h17, 5'h18, 5'h19, 5'h1A, 5'h1B:
                     rd_mux = idx[0] ? sn[idx[2:1]][15:8] : sn[idx[2:1]][7:0];
            default: rd_mux = 8'h00;
        endcase
    endfunction

    always_comb begin
        ptr_nxt   = auto_inc ? ptr + 5'd1 : ptr;
        rd_cur    = rd_mux(ptr, enable, atime, aint, avalid, snap);
        rd_nxt    = rd_mux(ptr_nxt, enable, atime, aint, avalid, snap);
        byte_full = (bit_cnt == 4'd8);
        cmd_sf    = (rx[6:5] == 2'b11);
        cmd_ok    = rx[7] && ((rx[6:5] == 2'b00) || (rx[6:5] == 2'b01) ||
                              (cmd_sf && (rx[4:0] == 5'b00110)));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, SDA drive and datapath strobes.
    always_comb begin
        state_next = state;
        sda_t_next = sda_t_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        rx_shift   = 1'b0;
        mack_latch = 1'b0;
        addr_hit   = 1'b0;
        cmd_hit    = 1'b0;
        wr_en      = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        ptr_inc    = 1'b0;
        tx_val     = rd_cur;
        if (ev_stop) begin
            state_next = IDLE;
            sda_t_next = 1'b1;
            cnt_clr    = 1'b1;
        end else if (ev_start) begin
            state_next = ADDR;
            sda_t_next = 1'b1;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                ADDR, CMD, WDATA: begin
                    if (ev_rise && !byte_full) rx_shift = 1'b1;
                    if (ev_fall && byte_full) begin
                        cnt_clr    = 1'b1;
                        state_next = WAIT;
                        if (state == ADDR && rx[7:1] == I2C_ADDR) begin
                            addr_hit   = 1'b1;
                            sda_t_next = 1'b0;
                            state_next = ADDR_ACK;
                        end else if (state == CMD && cmd_ok) begin
                            cmd_hit    = 1'b1;
                            sda_t_next = 1'b0;
                            state_next = CMD_ACK;
                        end else if (state == WDATA) begin
                            wr_en      = 1'b1;
                            ptr_inc    = 1'b1;
                            sda_t_next = 1'b0;
                            state_next = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: if (ev_fall) begin
                    if (rd_mode) begin
                        tx_load    = 1'b1;
                        sda_t_next = rd_cur[7];
                        state_next = RDATA;
                    end else begin
                        sda_t_next = 1'b1;
                        state_next = CMD;
                    end
                end
                CMD_ACK, WDATA_ACK: if (ev_fall) begin
                    sda_t_next = 1'b1;
                    state_next = WDATA;
                end
                RDATA: if (ev_fall) begin
                    if (bit_cnt == 4'd7) begin
                        cnt_clr    = 1'b1;
                        sda_t_next = 1'b1;
                        state_next = RDATA_ACK;
                    end else begin
                        tx_shift   = 1'b1;
                        cnt_inc    = 1'b1;
                        sda_t_next = tx[6];
                    end
                end
                RDATA_ACK: begin
                    if (ev_rise) mack_latch = 1'b1;
                    if (ev_fall) begin
                        if (!mack) begin
                            ptr_inc    = 1'b1;
                            tx_load    = 1'b1;
                            tx_val     = rd_nxt;
                            sda_t_next = rd_nxt[7];
                            state_next = RDATA;
                        end else begin
                            sda_t_next = 1'b1;
                            state_next = WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath, register file and sample capture; later assignments take priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            ptr      <= '0;
            auto_inc <= 1'b0;
            rd_mode  <= 1'b0;
            mack     <= 1'b1;
            sda_t_q  <= 1'b1;
            int_n_q  <= 1'b1;
            enable   <= 8'h00;
            atime    <= 8'hFF;
            aint     <= 1'b0;
            avalid   <= 1'b0;
            live     <= '0;
            snap     <= '0;
        end else begin
            sda_t_q <= sda_t_next;
            if (cnt_clr)                  bit_cnt <= '0;
            else if (rx_shift || cnt_inc) bit_cnt <= bit_cnt + 4'd1;
            if (rx_shift)   rx   <= {rx[6:0], bit_in};
            if (mack_latch) mack <= bit_in;
            if (tx_load)       tx <= tx_val;
            else if (tx_shift) tx <= {tx[6:0], 1'b0};
            if (addr_hit)          rd_mode <= rx[0];
            if (addr_hit && rx[0]) snap    <= live;
            if (cmd_hit && !cmd_sf) begin
                ptr      <= rx[4:0];
                auto_inc <= (rx[6:5] == 2'b01);
            end else if (ptr_inc && auto_inc) begin
                ptr <= ptr + 5'd1;
            end
            if (wr_en && ptr == 5'h00) begin
                enable <= rx & ENABLE_MASK;
                if (!rx[1]) avalid <= 1'b0;
            end
            if (wr_en && ptr == 5'h01) atime <= rx;
            if (cmd_hit && cmd_sf) aint <= 1'b0;
            if (bus.sample_valid && enable[1]) begin
                live   <= {bus.sample_b, bus.sample_g, bus.sample_r, bus.sample_c};
                avalid <= 1'b1;
                if (enable[4]) aint <= 1'b1;
            end
            int_n_q <= ~aint;
        end
    end

    assign bus.sda_o = 1'b0;
    assign bus.sda_t = sda_t_q;
    assign bus.int_n = int_n_q;
endmodule
